// File: rtl/generic_sram_byte_enable_if.sv
// Access bus of the byte-enable SRAM: address, write controls and registered read data.
// Master drives one request per clock; slave answers reads one edge later, no backpressure.
interface generic_sram_byte_enable_if #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
);
    logic [ADDRESS_WIDTH-1:0]  address;
    logic                      write_enable;
    logic [DATA_WIDTH/8-1:0]   byte_enable;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH-1:0]     read_data;

    modport master (
        output address,
        output write_enable,
        output byte_enable,
        output write_data,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_enable,
        input  byte_enable,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/generic_sram_byte_enable.sv
// Single-port SRAM with per-byte write masking; 1-cycle registered read, one access per clock.
// No backpressure: every cycle is accepted; read_data is zero on write and reset cycles.
module generic_sram_byte_enable #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
) (
    input  logic clk,
    input  logic reset,
    generic_sram_byte_enable_if.slave bus,
    input  logic scan_in0,
    input  logic scan_in1,
    input  logic scan_in2,
    input  logic scan_in3,
    input  logic scan_in4,
    input  logic scan_enable,
    input  logic test_mode,
    output logic scan_out0,
    output logic scan_out1,
    output logic scan_out2,
    output logic scan_out3,
    output logic scan_out4
);
    localparam int DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] read_q;

    // Storage is never reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && bus.write_enable) begin
            for (int n = 0; n < NUM_BYTES; n++) begin
                if (bus.byte_enable[n]) begin
                    mem[bus.address][8*n +: 8] <= bus.write_data[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= '0;
        end else if (bus.write_enable) begin
            read_q <= '0;
        end else begin
            read_q <= mem[bus.address];
        end
    end

    assign bus.read_data = read_q;

    // Scan chains are stitched by DFT insertion; functionally they are inert.
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    logic scan_unused;
    assign scan_unused = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode};
endmodule

// File: tb/tb_generic_sram_byte_enable.sv
// Directed bench for generic_sram_byte_enable: reset, masking, merging, boundaries, latency.
module tb_generic_sram_byte_enable;
    localparam int DW = 128;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic reset;
    logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
    logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int compared   = 0;
    int mismatched = 0;

    generic_sram_byte_enable_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    generic_sram_byte_enable #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

    always #5 clk = ~clk;

    localparam logic [DW-1:0] V_FULL  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DW-1:0] V_LOAA  = 128'h0123456789ABCDEF_FEDCBA98765432AA;
    localparam logic [DW-1:0] V_HIAA  = 128'hAA23456789ABCDEF_FEDCBA98765432AA;
    localparam logic [DW-1:0] V_MERGE = 128'hAA23456789ABCDEF_FEDCBA9876222211;
    localparam logic [DW-1:0] P0      = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [DW-1:0] P127    = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_scan(input string tag);
        logic [4:0] s;
        s = {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0};
        compared++;
        assert (s === 5'b0) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=00000", tag, s);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
        bus.write_enable = we;
        bus.address      = a;
        bus.byte_enable  = be;
        bus.write_data   = wd;
    endtask

    initial begin
        logic [DW-1:0] ones;
        ones = '1;
        {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode} = '0;

        // Reset held two cycles with a write pending: the write must be discarded.
        reset = 1'b1;
        drive(1'b1, 7'd5, 16'hFFFF, ones);
        tick();
        tick();
        check("reset_read_data", bus.read_data, '0);
        check_scan("scan_after_reset");

        reset = 1'b0;
        drive(1'b0, 7'd5, 16'h0000, '0);
        tick();
        compared++;
        assert (bus.read_data !== ones) else begin
            mismatched++;
            $error("FAIL reset_write_suppressed observed=%h expected=not_all_ones", bus.read_data);
        end

        // Full write then read.
        drive(1'b1, 7'd3, 16'hFFFF, V_FULL);
        tick();
        check("write_cycle_read_zero", bus.read_data, '0);
        drive(1'b0, 7'd3, 16'hFFFF, '0);
        tick();
        check("full_write_read", bus.read_data, V_FULL);

        drive(1'b1, 7'd3, 16'h0001, {16{8'hAA}});
        tick();
        drive(1'b0, 7'd3, 16'h0000, '0);
        tick();
        check("mask_low_byte", bus.read_data, V_LOAA);

        drive(1'b1, 7'd3, 16'h8000, {16{8'hAA}});
        tick();
        drive(1'b0, 7'd3, 16'h0000, '0);
        tick();
        check("mask_high_byte", bus.read_data, V_HIAA);

        drive(1'b1, 7'd3, 16'h0000, '0);
        tick();
        drive(1'b0, 7'd3, 16'h0000, '0);
        tick();
        check("zero_byte_enable", bus.read_data, V_HIAA);

        // Consecutive writes to one address merge byte-wise, later write wins.
        drive(1'b1, 7'd3, 16'h0003, {16{8'h11}});
        tick();
        drive(1'b1, 7'd3, 16'h0006, {16{8'h22}});
        tick();
        drive(1'b0, 7'd3, 16'h0000, '0);
        tick();
        check("back_to_back_merge", bus.read_data, V_MERGE);

        // Boundary addresses and read latency/hold.
        drive(1'b1, 7'd0, 16'hFFFF, P0);
        tick();
        drive(1'b1, 7'd127, 16'hFFFF, P127);
        tick();
        check("write_cycle_zero_127", bus.read_data, '0);
        drive(1'b0, 7'd0, 16'h0000, '0);
        #3;
        check("no_comb_path_addr0", bus.read_data, '0);
        tick();
        check("read_addr0", bus.read_data, P0);
        drive(1'b0, 7'd127, 16'h0000, '0);
        #3;
        check("hold_before_edge", bus.read_data, P0);
        tick();
        check("read_addr127", bus.read_data, P127);
        check_scan("scan_mid");
        tick();
        check("idle_hold_127", bus.read_data, P127);
        #3;
        check("idle_hold_mid", bus.read_data, P127);

        // Reset mid-sequence drops the write at that edge and keeps memory.
        reset = 1'b1;
        drive(1'b1, 7'd0, 16'hFFFF, ones);
        tick();
        check("mid_reset_read_zero", bus.read_data, '0);
        reset = 1'b0;
        drive(1'b0, 7'd0, 16'h0000, '0);
        tick();
        check("mid_reset_write_dropped", bus.read_data, P0);
        drive(1'b0, 7'd127, 16'h0000, '0);
        tick();
        check("mem_retained_127", bus.read_data, P127);
        check_scan("scan_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
